// File: rtl/retire_monitor_if.sv
// Retire-side commit bundle from writeback into the retire monitor.
// master drives the retiring instruction, slave observes it.
interface retire_monitor_if #(
  parameter int XLEN = 64
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_inst;
  logic [XLEN-1:0] commit_a0;

  modport master (
    output commit_valid,
    output commit_pc,
    output commit_inst,
    output commit_a0
  );

  modport slave (
    input commit_valid,
    input commit_pc,
    input commit_inst,
    input commit_a0
  );
endinterface

// File: rtl/retire_monitor.sv
// Retire monitor: counts commits, halts on ebreak or watchdog, drains, then
// presents one stable ebreak + exit code to sim. Trace: RETIRE_TRACE_EN.
module retire_monitor #(
  parameter int XLEN         = 64,
  parameter int WDOG_CYCLES  = 4096,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  retire_monitor_if.slave  cm,
  output logic             halt_req,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [XLEN-1:0]  halt_pc,
  output logic [31:0]      sim_inst,
  output logic [XLEN-1:0]  sim_r10,
  output logic [63:0]      instret,
  output logic [63:0]      cycle
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int WW = $clog2(WDOG_CYCLES);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WW-1:0]   wdog_q;
  logic [DW-1:0]   drain_q;
  logic [XLEN-1:0] exit_q;
  logic            is_ebreak;
  logic            timeout;

  assign is_ebreak = cm.commit_valid
                  && (cm.commit_inst == EBREAK);
  // A commit on the expiry cycle wins over the timeout
  assign timeout = !cm.commit_valid
                && (wdog_q == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (is_ebreak || timeout) state_d = DRAIN;
      DRAIN:   if (drain_q == '0) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halt_cause <= 2'd0;
      halt_pc    <= '0;
      exit_q     <= '0;
      instret    <= 64'd0;
      cycle      <= 64'd0;
      wdog_q     <= '0;
      drain_q    <= '0;
    end else begin
      if (state_q != HALT) cycle <= cycle + 64'd1;
      unique case (state_q)
        RUN: begin
          if (cm.commit_valid) begin
            instret <= instret + 64'd1;
            wdog_q  <= '0;
            halt_pc <= cm.commit_pc;
            if (is_ebreak) begin
              exit_q     <= cm.commit_a0;
              halt_cause <= 2'd1;
              drain_q    <= DW'(DRAIN_CYCLES - 1);
            end
          end else if (timeout) begin
            exit_q     <= XLEN'(1);
            halt_cause <= 2'd2;
            drain_q    <= DW'(DRAIN_CYCLES - 1);
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        DRAIN: if (drain_q != '0) drain_q <= drain_q - 1'b1;
        default: ;
      endcase
`ifdef RETIRE_TRACE_EN
      if (state_q == RUN && cm.commit_valid)
        $display("[%0d] pc=%h inst=%h",
                 cycle, cm.commit_pc, cm.commit_inst);
      if (state_q == DRAIN && state_d == HALT)
        $display("halt cause=%0d exit=%h", halt_cause, exit_q);
`endif
    end
  end

  // Outputs decode the state flop only; sim sees NOP until HALT
  always_comb begin
    halt_req = (state_q != RUN);
    halted   = (state_q == HALT);
    sim_inst = NOP;
    sim_r10  = '0;
    if (state_q == HALT) begin
      sim_inst = EBREAK;
      sim_r10  = exit_q;
    end
  end

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: edge-count model plus directed literal checks.
// Runs with WDOG_CYCLES=16 and DRAIN_CYCLES=2.
module tb_retire_monitor;

  localparam int W = 16;
  localparam int D = 2;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        halt_req;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [63:0] halt_pc;
  logic [31:0] sim_inst;
  logic [63:0] sim_r10;
  logic [63:0] instret;
  logic [63:0] cycle;

  int checks = 0;
  int errors = 0;

  retire_monitor_if #(.XLEN(64)) cm ();

  retire_monitor #(
    .XLEN(64), .WDOG_CYCLES(W), .DRAIN_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .cm(cm),
    .halt_req(halt_req), .halted(halted),
    .halt_cause(halt_cause), .halt_pc(halt_pc),
    .sim_inst(sim_inst), .sim_r10(sim_r10),
    .instret(instret), .cycle(cycle)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Model: count edges since reset, remember the edge that triggered a halt
  longint      m_e, m_trig, m_idle;
  logic [63:0] m_instret, m_pc, m_exit;
  logic [1:0]  m_cause;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_e <= 0; m_trig <= -1; m_idle <= 0;
      m_instret <= 0; m_pc <= 0; m_exit <= 0; m_cause <= 0;
    end else begin : upd
      longint e, tr, idl;
      logic [63:0] ir, pc, ex;
      logic [1:0] ca;
      e = m_e + 1; tr = m_trig; idl = m_idle;
      ir = m_instret; pc = m_pc; ex = m_exit; ca = m_cause;
      if (tr < 0) begin
        if (cm.commit_valid) begin
          ir = ir + 1; idl = 0; pc = cm.commit_pc;
          if (cm.commit_inst == EBREAK) begin
            ex = cm.commit_a0; ca = 1; tr = e;
          end
        end else begin
          idl = idl + 1;
          if (idl == W) begin ex = 1; ca = 2; tr = e; end
        end
      end
      m_e <= e; m_trig <= tr; m_idle <= idl;
      m_instret <= ir; m_pc <= pc; m_exit <= ex; m_cause <= ca;
    end
  end

  always @(negedge clock) begin
    if (reset) begin : cmp
      logic hd;
      longint cy;
      hd = (m_trig >= 0) && (m_e >= m_trig + D);
      cy = (m_trig < 0) ? m_e
         : ((m_e < m_trig + D) ? m_e : m_trig + D);
      chk("halt_req", 64'(halt_req), 64'(m_trig >= 0));
      chk("halted", 64'(halted), 64'(hd));
      chk("halt_cause", 64'(halt_cause), 64'(m_cause));
      chk("halt_pc", halt_pc, m_pc);
      chk("sim_inst", 64'(sim_inst), 64'(hd ? EBREAK : NOP));
      chk("sim_r10", sim_r10, hd ? m_exit : 64'd0);
      chk("instret", instret, m_instret);
      chk("cycle", cycle, 64'(cy));
    end
  end

  task automatic step(bit v, logic [63:0] pc,
                      logic [31:0] inst, logic [63:0] a0);
    cm.commit_valid = v;
    cm.commit_pc    = pc;
    cm.commit_inst  = inst;
    cm.commit_a0    = a0;
    @(negedge clock);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 64'd0, 32'd0, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cm.commit_valid = 1'b0;
    cm.commit_pc    = '0;
    cm.commit_inst  = '0;
    cm.commit_a0    = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_sim_inst", 64'(sim_inst), 64'h13);
    chk("rst_instret", instret, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);

    // five NOPs then ebreak with a0=0
    for (int i = 0; i < 5; i++)
      step(1'b1, 64'h8000_0000 + 64'(4 * i), NOP, 64'(i + 3));
    step(1'b1, 64'h8000_0014, EBREAK, 64'd0);
    chk("eb_halt_req", 64'(halt_req), 64'd1);
    chk("eb_n1_halted", 64'(halted), 64'd0);
    idle(1);
    chk("eb_n2_halted", 64'(halted), 64'd0);
    idle(1);
    chk("eb_halted", 64'(halted), 64'd1);
    chk("eb_instret", instret, 64'd6);
    chk("eb_cause", 64'(halt_cause), 64'd1);
    chk("eb_sim_inst", 64'(sim_inst), 64'h0010_0073);
    chk("eb_r10", sim_r10, 64'd0);
    chk("eb_pc", halt_pc, 64'h8000_0014);
    chk("eb_cycle", cycle, 64'd8);

    // commits during DRAIN must not disturb exit code or count
    do_reset();
    step(1'b1, 64'h200, EBREAK, 64'h2A);
    step(1'b1, 64'h204, NOP, 64'h55);
    step(1'b1, 64'h208, NOP, 64'h55);
    idle(2);
    chk("dr_r10", sim_r10, 64'h2A);
    chk("dr_instret", instret, 64'd1);
    chk("dr_pc", halt_pc, 64'h200);

    // watchdog from reset release
    do_reset();
    idle(W - 1);
    chk("wd_pre", 64'(halt_req), 64'd0);
    idle(1);
    chk("wd_req", 64'(halt_req), 64'd1);
    idle(2);
    chk("wd_halted", 64'(halted), 64'd1);
    chk("wd_cause", 64'(halt_cause), 64'd2);
    chk("wd_r10", sim_r10, 64'd1);
    chk("wd_pc", halt_pc, 64'd0);
    chk("wd_cycle", cycle, 64'd18);

    // commit on the expiry cycle wins and restarts the watchdog
    do_reset();
    idle(W - 1);
    step(1'b1, 64'h100, NOP, 64'd7);
    chk("wr_no_to", 64'(halt_req), 64'd0);
    idle(W - 1);
    chk("wr_pre", 64'(halt_req), 64'd0);
    idle(1);
    chk("wr_req", 64'(halt_req), 64'd1);
    idle(2);
    chk("wr_pc", halt_pc, 64'h100);
    chk("wr_cause", 64'(halt_cause), 64'd2);

    // asynchronous reset while halted
    #2 reset = 1'b0;
    #1;
    chk("ar_sim_inst", 64'(sim_inst), 64'h13);
    chk("ar_halted", 64'(halted), 64'd0);
    chk("ar_halt_req", 64'(halt_req), 64'd0);
    chk("ar_cause", 64'(halt_cause), 64'd0);
    chk("ar_cycle", cycle, 64'd0);
    chk("ar_r10", sim_r10, 64'd0);

    // alternating commits, then ebreak; cycle frozen in HALT
    do_reset();
    for (int i = 0; i < 10; i++)
      step(i % 2 == 0, 64'h1000 + 64'(4 * i), NOP, 64'(i));
    step(1'b1, 64'h1028, EBREAK, 64'h9);
    idle(2);
    chk("alt_instret", instret, 64'd6);
    chk("alt_cycle", cycle, 64'd13);
    chk("alt_r10", sim_r10, 64'h9);
    idle(4);
    chk("alt_frozen", cycle, 64'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
